// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and widths.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int WAIT_W    = 16;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-stall freeze, load-use interlock, branch flush,
// memory timeout detection, plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ifid_rsaddr_i,
  input  logic [4:0]       ifid_rtaddr_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rtaddr_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_hold_o,
  output logic             exmem_hold_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                freeze, load_use, stall_inc;

  assign load_use = idex_memread_i && (idex_rtaddr_i != 5'd0) &&
                    ((idex_rtaddr_i == ifid_rsaddr_i) ||
                     (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i)));
  assign wait_inc = wait_q + WAIT_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          freeze  = 1'b1;
          state_d = MEMWAIT;
          wait_d  = '0;
        end
      end
      MEMWAIT: begin
        // A ready cycle completes the access; it behaves exactly like RUN.
        if (!dmem_ready_i) begin
          freeze = 1'b1;
          if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERROR;
            wait_d  = '0;
          end else begin
            wait_d  = wait_inc;
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_hold_o    = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    stall_inc      = 1'b0;
    // Reset forces the plain RUN behaviour regardless of stored state.
    if (!rst_n_i) begin
      pc_write_o = 1'b1;
    end else if (state_q == ERROR) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_hold_o    = 1'b1;
      exmem_hold_o   = 1'b1;
      memwb_bubble_o = 1'b1;
      stall_inc      = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      stall_inc     = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign err_o = (state_q == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (ifid_flush_o),
    .cnt_o   (flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios, randomized traffic and counter saturation,
// all checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int TO   = 4;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [4:0]    ifid_rsaddr_i, ifid_rtaddr_i, idex_rtaddr_i;
  logic          ifid_uses_rt_i, idex_memread_i, branch_taken_i, dmem_req_i, dmem_ready_i;
  logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic          idex_hold_o, exmem_hold_o, memwb_bubble_o, err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .ifid_rsaddr_i  (ifid_rsaddr_i),
    .ifid_rtaddr_i  (ifid_rtaddr_i),
    .ifid_uses_rt_i (ifid_uses_rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rtaddr_i  (idex_rtaddr_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .idex_hold_o    (idex_hold_o),
    .exmem_hold_o   (exmem_hold_o),
    .memwb_bubble_o (memwb_bubble_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: waiting flag, consecutive-wait count, sticky error, event counts.
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stall;
  int m_flush;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, memwb_bubble}
  localparam logic [6:0] V_NONE   = 7'b1100000;
  localparam logic [6:0] V_BRANCH = 7'b1110000;
  localparam logic [6:0] V_LU     = 7'b0001000;
  localparam logic [6:0] V_FREEZE = 7'b0000111;
  localparam logic [6:0] V_ERR    = 7'b0001001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] dut_ctl();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
            idex_hold_o, exmem_hold_o, memwb_bubble_o};
  endfunction

  task automatic set_in(input bit mr, input int ex_rt, input int rs, input int rt,
                        input bit use_rt, input bit br, input bit req, input bit rdy);
    idex_memread_i = mr;
    idex_rtaddr_i  = 5'(ex_rt);
    ifid_rsaddr_i  = 5'(rs);
    ifid_rtaddr_i  = 5'(rt);
    ifid_uses_rt_i = use_rt;
    branch_taken_i = br;
    dmem_req_i     = req;
    dmem_ready_i   = rdy;
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic step(input bit do_chk);
    bit fz, lu, fl;
    logic [6:0] exp;
    #1;
    lu = idex_memread_i && idex_rtaddr_i != 0 &&
         (idex_rtaddr_i == ifid_rsaddr_i || (ifid_uses_rt_i && idex_rtaddr_i == ifid_rtaddr_i));
    fz = !m_err && (m_wait ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i));
    fl = !m_err && !fz && !lu && branch_taken_i;
    if (m_err)       exp = V_ERR;
    else if (fz)     exp = V_FREEZE;
    else if (lu)     exp = V_LU;
    else if (fl)     exp = V_BRANCH;
    else             exp = V_NONE;
    if (do_chk) begin
      chk("ctl", 32'(dut_ctl()), 32'(exp));
      chk("err", 32'(err_o), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
    end
    @(posedge clk_i);
    if (!m_err) begin
      if ((fz || lu) && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
      if (m_wait) begin
        if (dmem_ready_i) begin
          m_wait = 0;
          m_wcnt = 0;
        end else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_err  = 1;
            m_wait = 0;
            m_wcnt = 0;
          end
        end
      end else if (dmem_req_i && !dmem_ready_i) begin
        m_wait = 1;
        m_wcnt = 0;
      end
    end
    @(negedge clk_i);
  endtask

  // Reset asserted mid-cycle with hazardous inputs present; outputs must show plain RUN.
  task automatic do_reset();
    set_in(1, 8, 8, 8, 1, 1, 1, 0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_ctl", 32'(dut_ctl()), 32'(V_NONE));
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_flush", 32'(flush_cnt_o), 32'd0);
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1);

    // Load-use on rs
    set_in(1, 8, 8, 3, 0, 0, 0, 0); step(1);
    chk("lu_stall1", 32'(stall_cnt_o), 32'd1);
    // Load to r0 is never a hazard
    set_in(1, 0, 0, 0, 1, 0, 0, 0); step(1);
    chk("r0_nostall", 32'(stall_cnt_o), 32'd1);
    // Load-use via rt only when rt is a source
    set_in(1, 9, 1, 9, 0, 0, 0, 0); step(1);
    set_in(1, 9, 1, 9, 1, 0, 0, 0); step(1);
    chk("lu_rt", 32'(stall_cnt_o), 32'd2);
    // Three-cycle memory stall then ready
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1); step(1);
    chk("mem3_stall", 32'(stall_cnt_o), 32'd5);
    // Ready in the same cycle as the request: no stall
    step(1);
    chk("mem_fast", 32'(stall_cnt_o), 32'd5);
    // Load-use beats branch flush
    set_in(1, 8, 8, 0, 0, 1, 0, 0); step(1);
    chk("lu_br_flush", 32'(flush_cnt_o), 32'd0);
    set_in(0, 0, 0, 0, 0, 1, 0, 0); step(1);
    chk("br_flush", 32'(flush_cnt_o), 32'd1);
    // Timeout: one stall cycle in RUN then TO waiting cycles
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < TO + 1; i++) step(1);
    chk("timeout_err", 32'(err_o), 32'd1);
    set_in(1, 8, 8, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(1);
    chk("err_sticky", 32'(err_o), 32'd1);
    do_reset();
    step(1);
    chk("err_cleared", 32'(err_o), 32'd0);

    // Randomized traffic with small register ranges to make hazards frequent
    for (int n = 0; n < 3000; n++) begin
      if (m_err && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else if (!m_err && m_wait && $urandom_range(0, 40) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
      end
      step(1);
    end

    // Stall counter saturation
    do_reset();
    set_in(1, 5, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < CMAX; i++) step(0);
    chk("sat_reach", 32'(stall_cnt_o), 32'(CMAX));
    step(1);
    chk("sat_hold", 32'(stall_cnt_o), 32'(CMAX));
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, %0d checks made", n_chk);
    $fatal(1);
  end
endmodule
